// File: rtl/mem_access_unit.sv
// mem_access_unit
//  CPU-side initiator for a 16-bit big-endian data RAM (CS / RW_ / addr / data).
//  Turns load/store requests into RAM cycles:
//   word load  : IDLE -> RD -> RESP
//   byte load  : IDLE -> RD -> RESP           (lane extracted, sign/zero extended)
//   word store : IDLE -> WR -> RESP
//   byte store : IDLE -> RD -> WR -> RESP     (read-modify-write of one lane)
//   fault      : IDLE -> RESP                 (no RAM cycle at all)
//  Optional build macro: MAU_ALIGN_CHECK_EN
//   defined     -> word access at an odd address faults
//   not defined -> odd word addresses are legal, range check only
//  The memory-side outputs are decoded only from the state register and the
//  latched request registers, so they never depend on the live request inputs.
module mem_access_unit #(
  parameter logic [15:0] MEM_TOP = 16'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic        byte_op,
  input  logic        sext,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic [15:0] rdata,
  output logic        mem_cs,
  output logic        mem_rw_,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  // Latched request
  logic        wr_r;
  logic        byte_r;
  logic        sext_r;
  logic        lane_lo_r;   // 1: byte lives in [7:0], 0: byte lives in [15:8]
  logic [15:0] waddr_r;     // word address driven onto the RAM bus
  logic [15:0] wbuf_r;      // write data; becomes the merged word for byte stores
  logic        fault_r;
  logic [15:0] rdata_r;

  // Request decode on the live inputs (used only on the accepting edge)
  logic        req_fault_s;
  logic [15:0] req_waddr_s;
  logic        req_lane_lo_s;

  // RD-cycle datapath on the RAM read bus
  logic [7:0]  lane_s;
  logic [15:0] merged_s;
  logic [15:0] load_s;

  // Address legality, word address and byte lane for the incoming request
  always_comb begin
    req_fault_s   = 1'b0;
    req_waddr_s   = addr;
    req_lane_lo_s = 1'b0;
    if (byte_op) begin
      if (addr <= MEM_TOP) begin
        req_waddr_s   = addr;
        req_lane_lo_s = 1'b0;
      end else if (addr == (MEM_TOP + 16'd1)) begin
        // Last byte of memory: reach it through the word that ends there.
        req_waddr_s   = addr - 16'd1;
        req_lane_lo_s = 1'b1;
      end else begin
        req_fault_s   = 1'b1;
      end
    end else begin
`ifdef MAU_ALIGN_CHECK_EN
      req_fault_s = (addr > MEM_TOP) | addr[0];
`else
      req_fault_s = (addr > MEM_TOP);
`endif
    end
  end

  // Lane selection, byte-store merge and load-result formatting from RAM data
  always_comb begin
    lane_s   = 8'h00;
    merged_s = 16'h0000;
    load_s   = 16'h0000;
    if (lane_lo_r) begin
      lane_s   = mem_rdata[7:0];
      merged_s = {mem_rdata[15:8], wbuf_r[7:0]};
    end else begin
      lane_s   = mem_rdata[15:8];
      merged_s = {wbuf_r[7:0], mem_rdata[7:0]};
    end
    if (byte_r) begin
      load_s = {{8{sext_r & lane_s[7]}}, lane_s};
    end else begin
      load_s = mem_rdata;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (req_fault_s) begin
            state_nxt_s = RESP;
          end else if (!wr || byte_op) begin
            state_nxt_s = RD;
          end else begin
            state_nxt_s = WR;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        if (wr_r) begin
          state_nxt_s = WR;
        end else begin
          state_nxt_s = RESP;
        end
      end
      WR:      state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch, RD capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_r      <= 1'b0;
      byte_r    <= 1'b0;
      sext_r    <= 1'b0;
      lane_lo_r <= 1'b0;
      waddr_r   <= 16'h0000;
      wbuf_r    <= 16'h0000;
      fault_r   <= 1'b0;
      rdata_r   <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            wr_r      <= wr;
            byte_r    <= byte_op;
            sext_r    <= sext;
            lane_lo_r <= req_lane_lo_s;
            waddr_r   <= req_waddr_s;
            wbuf_r    <= wdata;
            fault_r   <= req_fault_s;
            rdata_r   <= 16'h0000;
          end
        end
        RD: begin
          // The only cycle in which the RAM read bus is looked at.
          if (wr_r) begin
            wbuf_r <= merged_s;
          end else begin
            rdata_r <= load_s;
          end
        end
        RESP: begin
          fault_r <= 1'b0;
          rdata_r <= 16'h0000;
        end
        default: begin
          fault_r <= fault_r;
        end
      endcase
    end
  end

  // Handshake and RAM bus decode from state and latched registers
  always_comb begin
    ready     = (state_r == IDLE);
    done      = (state_r == RESP);
    fault     = (state_r == RESP) & fault_r;
    rdata     = rdata_r;
    mem_cs    = (state_r == RD) || (state_r == WR);
    mem_rw_   = (state_r != WR);
    if (mem_cs) begin
      mem_addr = waddr_r;
    end else begin
      mem_addr = 16'h0000;
    end
    if (state_r == WR) begin
      mem_wdata = wbuf_r;
    end else begin
      mem_wdata = 16'h0000;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array big-endian RAM model.
// The driver pushes the expected response of each request; a negedge monitor
// pops and compares whenever done is seen.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic        byte_op;
  logic        sext;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        done;
  logic        fault;
  logic [15:0] rdata;
  logic        mem_cs;
  logic        mem_rw_;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        ram_clr;
  logic [7:0]  ram [0:31];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int cs_cnt = 0;
  logic [15:0] last_rd_addr = 16'h0000;

  typedef struct packed {
    logic        f;
    logic [15:0] d;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb [$];

  mem_access_unit #(.MEM_TOP(16'd14)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .byte_op(byte_op), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .fault(fault),
    .rdata(rdata), .mem_cs(mem_cs), .mem_rw_(mem_rw_), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Big-endian RAM: word at A = {ram[A], ram[A+1]}
  assign mem_rdata = (mem_cs && mem_rw_) ?
                     {ram[mem_addr[4:0]], ram[mem_addr[4:0] + 5'd1]} : 16'hzzzz;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'h00;
    end else if (mem_cs && !mem_rw_) begin
      ram[mem_addr[4:0]]        <= mem_wdata[15:8];
      ram[mem_addr[4:0] + 5'd1] <= mem_wdata[7:0];
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  // Monitor: scoreboard compare on every done
  always @(negedge clk) begin
    exp_t e;
    if (mem_cs) cs_cnt++;
    if (mem_cs && mem_rw_) last_rd_addr = mem_addr;
    if (done) begin
      chk("ready_with_done", {15'd0, ready}, 16'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        e = sb.pop_front();
        chk("fault", {15'd0, fault}, {15'd0, e.f});
        chk("rdata", rdata, e.d);
        chk("latency", 16'(cyc - e.acc), 16'(e.lat));
      end
      done_cnt++;
    end
  end

  task automatic xact(input logic w, input logic b, input logic s,
                      input logic [15:0] a, input logic [15:0] wd,
                      input logic ef, input logic [15:0] ed, input int el);
    exp_t e;
    int t;
    int dc0;
    int cs0;
    @(negedge clk);
    t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("ready_timeout", 16'd0, 16'd1);
    e.f = ef; e.d = ed; e.lat = el; e.acc = cyc;
    sb.push_back(e);
    dc0 = done_cnt;
    cs0 = cs_cnt;
    req = 1'b1; wr = w; byte_op = b; sext = s; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    t = 0;
    while (done_cnt == dc0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == dc0) chk("done_timeout", 16'd0, 16'd1);
    chk("cs_cycles", 16'(cs_cnt - cs0), ef ? 16'd0 : 16'(el - 1));
  endtask

  initial begin
    int dc0;
    rst = 1'b1; ram_clr = 1'b1;
    req = 1'b0; wr = 1'b0; byte_op = 1'b0; sext = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_fault", {15'd0, fault}, 16'd0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_cs", {15'd0, mem_cs}, 16'd0);
    chk("rst_rw", {15'd0, mem_rw_}, 16'd1);
    chk("rst_maddr", mem_addr, 16'h0000);
    chk("rst_mwdata", mem_wdata, 16'h0000);
    rst = 1'b0; ram_clr = 1'b0;

    // Word store / load
    xact(1'b1, 1'b0, 1'b0, 16'd4, 16'hBEEF, 1'b0, 16'h0000, 2);
    chk("ram4_ws", {8'h00, ram[4]}, 16'h00BE);
    chk("ram5_ws", {8'h00, ram[5]}, 16'h00EF);
    xact(1'b0, 1'b0, 1'b0, 16'd4, 16'h0000, 1'b0, 16'hBEEF, 2);

    // Byte store high lane, read back
    xact(1'b1, 1'b1, 1'b0, 16'd4, 16'h0012, 1'b0, 16'h0000, 3);
    chk("ram4_bs", {8'h00, ram[4]}, 16'h0012);
    chk("ram5_bs", {8'h00, ram[5]}, 16'h00EF);
    xact(1'b0, 1'b0, 1'b0, 16'd4, 16'h0000, 1'b0, 16'h12EF, 2);

    // Byte loads with sign / zero extension
    xact(1'b0, 1'b1, 1'b1, 16'd5, 16'h0000, 1'b0, 16'hFFEF, 2);
    xact(1'b0, 1'b1, 1'b0, 16'd5, 16'h0000, 1'b0, 16'h00EF, 2);

    // Top of memory: byte at 15 goes through word 14, low lane
    xact(1'b1, 1'b0, 1'b0, 16'd14, 16'h3C9E, 1'b0, 16'h0000, 2);
    xact(1'b0, 1'b1, 1'b1, 16'd15, 16'h0000, 1'b0, 16'hFF9E, 2);
    chk("top_rd_addr", last_rd_addr, 16'd14);
    xact(1'b1, 1'b1, 1'b0, 16'd15, 16'hAA77, 1'b0, 16'h0000, 3);
    chk("ram14_bs", {8'h00, ram[14]}, 16'h003C);
    chk("ram15_bs", {8'h00, ram[15]}, 16'h0077);
    xact(1'b0, 1'b0, 1'b0, 16'd14, 16'h0000, 1'b0, 16'h3C77, 2);

    // Out of range: faults, no RAM cycle
    xact(1'b0, 1'b0, 1'b0, 16'd15, 16'h0000, 1'b1, 16'h0000, 1);
    xact(1'b0, 1'b1, 1'b0, 16'd16, 16'h0000, 1'b1, 16'h0000, 1);
    xact(1'b1, 1'b1, 1'b0, 16'd16, 16'h0055, 1'b1, 16'h0000, 1);
    xact(1'b1, 1'b0, 1'b0, 16'd15, 16'h1111, 1'b1, 16'h0000, 1);
    chk("ram15_fault", {8'h00, ram[15]}, 16'h0077);
    chk("ram16_fault", {8'h00, ram[16]}, 16'h0000);

    // Reset during RD of a byte store
    @(negedge clk);
    dc0 = done_cnt;
    req = 1'b1; wr = 1'b1; byte_op = 1'b1; sext = 1'b0; addr = 16'd4; wdata = 16'h00AA;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("rd_before_rst", {15'd0, mem_cs}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {15'd0, ready}, 16'd1);
    chk("mid_rst_cs", {15'd0, mem_cs}, 16'd0);
    chk("mid_rst_rw", {15'd0, mem_rw_}, 16'd1);
    chk("mid_rst_maddr", mem_addr, 16'h0000);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_done", 16'(done_cnt - dc0), 16'd0);
    chk("ram4_rst", {8'h00, ram[4]}, 16'h0012);
    chk("ram5_rst", {8'h00, ram[5]}, 16'h00EF);

    // Odd word address
`ifdef MAU_ALIGN_CHECK_EN
    xact(1'b1, 1'b0, 1'b0, 16'd3, 16'h1234, 1'b1, 16'h0000, 1);
    chk("ram3_align", {8'h00, ram[3]}, 16'h0000);
    chk("ram4_align", {8'h00, ram[4]}, 16'h0012);
`else
    xact(1'b1, 1'b0, 1'b0, 16'd3, 16'h1234, 1'b0, 16'h0000, 2);
    chk("ram3_odd", {8'h00, ram[3]}, 16'h0012);
    chk("ram4_odd", {8'h00, ram[4]}, 16'h0034);
    xact(1'b0, 1'b0, 1'b0, 16'd3, 16'h0000, 1'b0, 16'h1234, 2);
`endif

    // Byte store uses only wdata[7:0]
    xact(1'b1, 1'b1, 1'b0, 16'd0, 16'hFF56, 1'b0, 16'h0000, 3);
    xact(1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 16'h5600, 2);

    repeat (3) @(negedge clk);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
